// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage pipeline: shadow scoreboard, stage enables, bubbles, stall counter.
// Define PIPE_FWD_EN to enable EX/MEM/WB forwarding (only load-use dependences stall).
module pipe_hazard_ctrl #(
    parameter int unsigned STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [4:0]             id_rs,
    input  logic [4:0]             id_rt,
    input  logic                   id_rs_used,
    input  logic                   id_rt_used,
    input  logic                   id_wen,
    input  logic [4:0]             id_dest,
    input  logic                   id_is_load,
    input  logic                   id_br_taken,
    input  logic                   mem_stall,
    output logic                   pc_en,
    output logic                   id2ex_en,
    output logic                   id2ex_bubble,
    output logic                   ex2mem_en,
    output logic                   mem2wb_en,
    output logic                   br_taken_out,
    output logic [1:0]             fwd_a_sel,
    output logic [1:0]             fwd_b_sel,
    output logic                   ex_valid,
    output logic                   mem_valid,
    output logic                   wb_valid,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic       valid;
        logic       wen;
        logic [4:0] dest;
        logic       load;
    } sb_ent_t;

    sb_ent_t                r_ex;
    sb_ent_t                r_mem;
    sb_ent_t                r_wb;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    logic [2:0] w_match_a;
    logic [2:0] w_match_b;
    logic       w_dep_a;
    logic       w_dep_b;
    logic       w_hazard;
    logic       w_bubble;
    logic       w_unused;

    // Per-stage producer match for each ID source; register 0 never matches.
    always_comb begin
        w_match_a[0] = r_ex.valid  & r_ex.wen  & (r_ex.dest  == id_rs) & (id_rs != 5'd0);
        w_match_a[1] = r_mem.valid & r_mem.wen & (r_mem.dest == id_rs) & (id_rs != 5'd0);
        w_match_a[2] = r_wb.valid  & r_wb.wen  & (r_wb.dest  == id_rs) & (id_rs != 5'd0);
        w_match_b[0] = r_ex.valid  & r_ex.wen  & (r_ex.dest  == id_rt) & (id_rt != 5'd0);
        w_match_b[1] = r_mem.valid & r_mem.wen & (r_mem.dest == id_rt) & (id_rt != 5'd0);
        w_match_b[2] = r_wb.valid  & r_wb.wen  & (r_wb.dest  == id_rt) & (id_rt != 5'd0);
    end

`ifdef PIPE_FWD_EN
    // Load data only exists in WB, so a load still in EX or MEM must stall.
    assign w_dep_a = id_rs_used & ((w_match_a[0] & r_ex.load) | (w_match_a[1] & r_mem.load));
    assign w_dep_b = id_rt_used & ((w_match_b[0] & r_ex.load) | (w_match_b[1] & r_mem.load));

    always_comb begin
        fwd_a_sel = 2'd0;
        fwd_b_sel = 2'd0;
        if (w_match_a[0])      fwd_a_sel = 2'd1;
        else if (w_match_a[1]) fwd_a_sel = 2'd2;
        else if (w_match_a[2]) fwd_a_sel = 2'd3;
        if (w_match_b[0])      fwd_b_sel = 2'd1;
        else if (w_match_b[1]) fwd_b_sel = 2'd2;
        else if (w_match_b[2]) fwd_b_sel = 2'd3;
    end
`else
    // No forwarding and no regfile write-through: wait until the producer leaves WB.
    assign w_dep_a   = id_rs_used & (|w_match_a);
    assign w_dep_b   = id_rt_used & (|w_match_b);
    assign fwd_a_sel = 2'd0;
    assign fwd_b_sel = 2'd0;
`endif

    assign w_hazard = id_valid & (w_dep_a | w_dep_b);
    assign w_bubble = w_hazard | ~id_valid;

    assign pc_en        = ~w_hazard & ~mem_stall;
    assign id2ex_en     = ~mem_stall;
    assign ex2mem_en    = ~mem_stall;
    assign mem2wb_en    = ~mem_stall;
    assign id2ex_bubble = w_bubble;
    assign br_taken_out = id_br_taken & id_valid & ~w_hazard & ~mem_stall;

    assign ex_valid  = r_ex.valid;
    assign mem_valid = r_mem.valid;
    assign wb_valid  = r_wb.valid;
    assign stall_cnt = r_stall_cnt;

    // The WB load bit is tracked for completeness but no decision depends on it.
    assign w_unused = r_wb.load;

    // Shadow scoreboard advances with the pipeline; mem_stall freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex        <= '0;
            r_mem       <= '0;
            r_wb        <= '0;
            r_stall_cnt <= '0;
        end else if (!mem_stall) begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            if (w_bubble) r_ex <= '0;
            else          r_ex <= '{valid: 1'b1, wen: id_wen, dest: id_dest, load: id_is_load};
            if (w_hazard && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed hazard scenarios plus random traffic against a
// list-of-in-flight-instructions reference model. Honours PIPE_FWD_EN like the design.
module tb_pipe_hazard_ctrl;

    localparam int unsigned CW   = 4;
    localparam int unsigned MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid, id_rs_used, id_rt_used, id_wen, id_is_load, id_br_taken, mem_stall;
    logic [4:0]    id_rs, id_rt, id_dest;
    logic          pc_en, id2ex_en, id2ex_bubble, ex2mem_en, mem2wb_en, br_taken_out;
    logic [1:0]    fwd_a_sel, fwd_b_sel;
    logic          ex_valid, mem_valid, wb_valid;
    logic [CW-1:0] stall_cnt;

    pipe_hazard_ctrl #(.STALL_CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_wen(id_wen), .id_dest(id_dest), .id_is_load(id_is_load),
        .id_br_taken(id_br_taken), .mem_stall(mem_stall),
        .pc_en(pc_en), .id2ex_en(id2ex_en), .id2ex_bubble(id2ex_bubble),
        .ex2mem_en(ex2mem_en), .mem2wb_en(mem2wb_en), .br_taken_out(br_taken_out),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

`ifdef PIPE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // Reference model: instructions in flight, index 0 = EX, 1 = MEM, 2 = WB.
    typedef struct {
        bit       v;
        bit       w;
        bit [4:0] d;
        bit       ld;
    } ent_t;

    ent_t        sh[3];
    int unsigned m_cnt;
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          e_haz, e_pc;
    bit [1:0]    e_fa, e_fb;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit writes(int s, bit [4:0] r);
        return sh[s].v && sh[s].w && (sh[s].d == r) && (r != 5'd0);
    endfunction

    function automatic bit [1:0] fwd_of(bit [4:0] r);
        if (!FWD) return 2'd0;
        for (int s = 0; s < 3; s++)
            if (writes(s, r)) return 2'(s + 1);
        return 2'd0;
    endfunction

    function automatic bit needs_stall(bit [4:0] r);
        for (int s = 0; s < 3; s++) begin
            if (writes(s, r)) begin
                if (!FWD) return 1'b1;
                if (s < 2 && sh[s].ld) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 3; s++) sh[s] = '{v: 0, w: 0, d: 5'd0, ld: 0};
        m_cnt = 0;
    endtask

    // Compare one cycle against the model, then clock it and advance the model.
    task automatic step();
        #1;
        e_haz = id_valid && ((id_rs_used && needs_stall(id_rs)) || (id_rt_used && needs_stall(id_rt)));
        e_pc  = !e_haz && !mem_stall;
        e_fa  = fwd_of(id_rs);
        e_fb  = fwd_of(id_rt);
        check("pc_en", 32'(pc_en), 32'(e_pc));
        check("id2ex_en", 32'(id2ex_en), 32'(!mem_stall));
        check("ex2mem_en", 32'(ex2mem_en), 32'(!mem_stall));
        check("mem2wb_en", 32'(mem2wb_en), 32'(!mem_stall));
        check("bubble", 32'(id2ex_bubble), 32'(e_haz || !id_valid));
        check("br_out", 32'(br_taken_out), 32'(id_br_taken && id_valid && e_pc));
        check("ex_valid", 32'(ex_valid), 32'(sh[0].v));
        check("mem_valid", 32'(mem_valid), 32'(sh[1].v));
        check("wb_valid", 32'(wb_valid), 32'(sh[2].v));
        check("stall_cnt", 32'(stall_cnt), m_cnt);
        if (!e_haz && id_valid && id_rs_used) check("fwd_a", 32'(fwd_a_sel), 32'(e_fa));
        if (!e_haz && id_valid && id_rt_used) check("fwd_b", 32'(fwd_b_sel), 32'(e_fb));
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (!mem_stall) begin
            if (e_haz && m_cnt < MAXC) m_cnt++;
            sh[2] = sh[1];
            sh[1] = sh[0];
            if (e_haz || !id_valid) sh[0] = '{v: 0, w: 0, d: 5'd0, ld: 0};
            else sh[0] = '{v: 1, w: id_wen, d: id_dest, ld: id_is_load};
        end
        @(negedge clk);
    endtask

    task automatic set_id(input bit v, input bit [4:0] rs, input bit [4:0] rt, input bit rsu,
                          input bit rtu, input bit w, input bit [4:0] d, input bit ld, input bit br);
        id_valid = v; id_rs = rs; id_rt = rt; id_rs_used = rsu; id_rt_used = rtu;
        id_wen = w; id_dest = d; id_is_load = ld; id_br_taken = br;
    endtask

    int  stalls, brs;
    bit  done;
    logic [1:0] fb_rel;

    initial begin
        rst = 1'b1;
        mem_stall = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(posedge clk);
        model_reset();
        @(negedge clk);
        step();
        rst = 1'b0;

        // Fresh pipeline: nothing in flight, nothing to wait on.
        set_id(1, 5'd1, 5'd2, 1, 1, 0, 5'd0, 0, 0);
        #1;
        check("rst_pc_en", 32'(pc_en), 32'd1);
        check("rst_bubble", 32'(id2ex_bubble), 32'd0);
        check("rst_fwd_a", 32'(fwd_a_sel), 32'd0);
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        check("rst_valids", 32'({ex_valid, mem_valid, wb_valid}), 32'd0);
        step();

        // LW r5 then a taken branch reading r5, with a 4-cycle memory freeze inside the hazard.
        set_id(1, 5'd0, 5'd0, 0, 0, 1, 5'd5, 1, 0);
        step();
        set_id(1, 5'd0, 5'd5, 0, 1, 1, 5'd6, 0, 1);
        stalls = 0; brs = 0; done = 1'b0; fb_rel = 2'd0;
        for (int i = 0; i < 12 && !done; i++) begin
            mem_stall = (i >= 1 && i <= 4);
            #1;
            if (!pc_en && !mem_stall) stalls++;
            if (br_taken_out) brs++;
            if (pc_en) begin
                done = 1'b1;
                fb_rel = fwd_b_sel;
            end
            step();
        end
        mem_stall = 1'b0;
        check("lu_released", 32'(done), 32'd1);
        check("lu_stall_cycles", 32'(stalls), FWD ? 32'd2 : 32'd3);
        check("lu_br_pulses", 32'(brs), 32'd1);
        check("lu_fwd_b", 32'(fb_rel), FWD ? 32'd3 : 32'd0);
        check("lu_stall_cnt", 32'(stall_cnt), FWD ? 32'd2 : 32'd3);

        // A write to r0 never creates a dependence.
        set_id(1, 5'd0, 5'd0, 0, 0, 1, 5'd0, 0, 0);
        step();
        set_id(1, 5'd0, 5'd0, 1, 1, 0, 5'd0, 0, 0);
        #1;
        check("r0_no_stall", 32'(pc_en), 32'd1);
        step();

`ifdef PIPE_FWD_EN
        // ALU result forwarded from EX, then from MEM.
        set_id(1, 5'd0, 5'd0, 0, 0, 1, 5'd3, 0, 0);
        step();
        set_id(1, 5'd3, 5'd0, 1, 0, 1, 5'd4, 0, 0);
        #1;
        check("fwd_ex", 32'(fwd_a_sel), 32'd1);
        check("fwd_ex_nostall", 32'(pc_en), 32'd1);
        step();
        set_id(1, 5'd3, 5'd0, 1, 0, 0, 5'd0, 0, 0);
        #1;
        check("fwd_mem", 32'(fwd_a_sel), 32'd2);
        step();
`endif

        // Random traffic over a small register set so dependences are frequent.
        e_pc = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            mem_stall = ($urandom_range(0, 7) == 0);
            if (e_pc || !id_valid) begin
                set_id($urandom_range(0, 5) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                       1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                       $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0);
            end
            step();
        end
        check("stall_cnt_sat", 32'(stall_cnt), MAXC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
